reg_read_scoreboard: RTL and testbench

//  Read-side companion to the register file in the MIPS pipeline. Tracks in-flight

---
 rtl/reg_read_scoreboard.sv | 110 +++++++++++
 tb/tb_reg_read_scoreboard.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_read_scoreboard.sv
// Register read scoreboard: per-register in-flight write counters, decode stall and ID operand select.
// Optional same-cycle writeback bypass is enabled by defining SB_BYPASS_EN.
module reg_read_scoreboard #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [AW-1:0]     id_rd,
  input  logic [DW-1:0]     rf_rd1,
  input  logic [DW-1:0]     rf_rd2,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_wa,
  input  logic [DW-1:0]     wb_wd,
  output logic              stall,
  output logic              issue,
  output logic [DW-1:0]     op_a,
  output logic [DW-1:0]     op_b,
  output logic [2**AW-1:0]  pend_mask,
  output logic              sb_err
);

  localparam int            NREG     = 2**AW;
  localparam logic [CW-1:0] MAX_PEND = '1;

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic          err_q, err_d;
  logic [NREG-1:0] pend_vec;
  logic          wb_hit, wb_dec, sat_stall, inc_any;

  // A writeback only retires an in-flight write if one is actually counted.
  assign wb_hit = wb_we & (wb_wa != '0);
  assign wb_dec = wb_hit & (cnt_q[wb_wa] != '0);

  always_comb begin
    pend_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      pend_vec[r] = (cnt_q[r] != '0);
`ifdef SB_BYPASS_EN
      if ((cnt_q[r] == CW'(1)) && wb_we && (wb_wa == AW'(r)))
        pend_vec[r] = 1'b0;
`endif
    end
  end

  // Refuse issue when the destination counter is full, unless a retire frees a slot now.
  assign sat_stall = id_wr_en & (id_rd != '0) & (cnt_q[id_rd] == MAX_PEND)
                   & ~(wb_dec & (wb_wa == id_rd));

  assign stall = id_valid & ((id_use_rs & pend_vec[id_rs])
                           | (id_use_rt & pend_vec[id_rt])
                           | sat_stall);
  assign issue   = id_valid & ~stall;
  assign inc_any = issue & id_wr_en & (id_rd != '0);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else begin
        case ({inc_any && (id_rd == AW'(r)), wb_dec && (wb_wa == AW'(r))})
          2'b10:   cnt_d[r] = cnt_q[r] + CW'(1);
          2'b01:   cnt_d[r] = cnt_q[r] - CW'(1);
          default: cnt_d[r] = cnt_q[r];
        endcase
      end
    end
  end

  assign err_d = err_q | (wb_hit & (cnt_q[wb_wa] == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) pend_mask[r] = (cnt_q[r] != '0);
  end
  assign sb_err = err_q;

  always_comb begin
    op_a = (id_rs == '0) ? '0 : rf_rd1;
    op_b = (id_rt == '0) ? '0 : rf_rd2;
`ifdef SB_BYPASS_EN
    if (wb_hit && (wb_wa == id_rs)) op_a = wb_wd;
    if (wb_hit && (wb_wa == id_rt)) op_b = wb_wd;
`endif
  end

`ifndef SB_BYPASS_EN
  logic unused_wd;
  assign unused_wd = ^wb_wd;
`endif

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Directed bench for reg_read_scoreboard: reset, RAW, r0, saturation, simultaneous inc/dec, underflow.
module tb_reg_read_scoreboard;

  logic        clk, rst;
  logic        id_valid, id_use_rs, id_use_rt, id_wr_en, wb_we;
  logic [4:0]  id_rs, id_rt, id_rd, wb_wa;
  logic [31:0] rf_rd1, rf_rd2, wb_wd;
  logic        stall, issue, sb_err;
  logic [31:0] op_a, op_b, pend_mask;

  int n_checks = 0;
  int n_pass   = 0;

  reg_read_scoreboard dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_en(id_wr_en), .id_rd(id_rd),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .stall(stall), .issue(issue), .op_a(op_a), .op_b(op_b),
    .pend_mask(pend_mask), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks sample 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs = 0; id_use_rt = 0; id_wr_en = 0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    wb_we = 0; wb_wa = 0; wb_wd = 0;
  endtask

  task automatic drive_wr(input logic [4:0] rd);
    id_valid = 1; id_wr_en = 1; id_rd = rd; id_use_rs = 0; id_use_rt = 0;
  endtask

  task automatic drive_wb(input logic [4:0] wa, input logic [31:0] wd);
    wb_we = 1; wb_wa = wa; wb_wd = wd;
  endtask

  initial begin
    idle();
    rf_rd1 = 32'h0; rf_rd2 = 32'h0;
    rst = 0;
    #12;
    rst = 1;
    tick();
    #1;
    check("reset_pend_mask", pend_mask, 32'h0);
    check("reset_sb_err", {31'b0, sb_err}, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);

    // RAW on r5
    drive_wr(5'd5); #1;
    check("raw_first_issue", {31'b0, issue}, 32'h1);
    tick();
    idle(); id_valid = 1; id_use_rs = 1; id_rs = 5'd5; rf_rd1 = 32'h0; #1;
    check("raw_pend5", pend_mask, 32'h0000_0020);
    check("raw_stall", {31'b0, stall}, 32'h1);
    tick(); #1;
    check("raw_stall_hold", {31'b0, stall}, 32'h1);
    drive_wb(5'd5, 32'hDEADBEEF); #1;
`ifdef SB_BYPASS_EN
    check("raw_wb_cycle_stall", {31'b0, stall}, 32'h0);
    check("raw_wb_bypass_op_a", op_a, 32'hDEADBEEF);
`else
    check("raw_wb_cycle_stall", {31'b0, stall}, 32'h1);
`endif
    tick();
    wb_we = 0; rf_rd1 = 32'hDEADBEEF; #1;
    check("raw_after_wb_stall", {31'b0, stall}, 32'h0);
    check("raw_after_wb_op_a", op_a, 32'hDEADBEEF);
    check("raw_after_wb_pend", pend_mask, 32'h0);

    // r0 writes and reads
    idle(); drive_wr(5'd0); tick(); tick();
    idle(); #1;
    check("r0_pend_mask", pend_mask, 32'h0);
    id_valid = 1; id_use_rs = 1; id_rs = 0; id_use_rt = 1; id_rt = 5'd4;
    rf_rd1 = 32'hFFFF_FFFF; rf_rd2 = 32'h1234_5678; #1;
    check("r0_stall", {31'b0, stall}, 32'h0);
    check("r0_op_a", op_a, 32'h0);
    check("r0_op_b_reg4", op_b, 32'h1234_5678);

    // saturation on r7
    idle(); tick();
    drive_wr(5'd7);
    for (int i = 0; i < 3; i++) tick();
    #1;
    check("sat_pend7", pend_mask, 32'h0000_0080);
    check("sat_stall", {31'b0, stall}, 32'h1);
    check("sat_issue", {31'b0, issue}, 32'h0);
    drive_wb(5'd7, 32'h0); #1;
    check("sat_wb_stall", {31'b0, stall}, 32'h0);
    check("sat_wb_issue", {31'b0, issue}, 32'h1);
    tick();
    wb_we = 0; #1;
    check("sat_still_full", {31'b0, stall}, 32'h1);
    idle(); drive_wb(5'd7, 32'h0);
    tick(); tick(); #1;
    check("sat_one_left", pend_mask, 32'h0000_0080);
    tick(); wb_we = 0; #1;
    check("sat_drained", pend_mask, 32'h0);
    check("sat_no_err", {31'b0, sb_err}, 32'h0);

    // simultaneous inc/dec on r9
    idle(); drive_wr(5'd9); tick();
    drive_wb(5'd9, 32'h0); #1;
    check("simul_issue", {31'b0, issue}, 32'h1);
    tick();
    idle(); #1;
    check("simul_pend9", pend_mask, 32'h0000_0200);
    drive_wb(5'd9, 32'h0); tick(); idle(); #1;
    check("simul_cnt_was_1", pend_mask, 32'h0);

    // underflow on r12
    drive_wb(5'd12, 32'h0); #1;
    check("uf_err_before_edge", {31'b0, sb_err}, 32'h0);
    tick(); idle(); #1;
    check("uf_err_set", {31'b0, sb_err}, 32'h1);
    check("uf_cnt12_zero", pend_mask, 32'h0);
    tick(); tick(); #1;
    check("uf_err_sticky", {31'b0, sb_err}, 32'h1);

    // async reset with pending state
    drive_wr(5'd3); tick();
    idle(); id_valid = 1; id_use_rs = 1; id_rs = 5'd3; #1;
    check("ar_pend3_before", pend_mask, 32'h0000_0008);
    @(negedge clk);
    rst = 0; #1;
    check("ar_pend_mask", pend_mask, 32'h0);
    check("ar_sb_err", {31'b0, sb_err}, 32'h0);
    check("ar_stall", {31'b0, stall}, 32'h0);
    #10; rst = 1; idle(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
